// File: rtl/seg_scan_display_if.sv
// rtl/seg_scan_display_if.sv - content load and handshake bundle for seg_scan_display
interface seg_scan_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] glyph_in;
  logic [NUM_DIGITS-1:0]   digit_en_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blink_in;
  logic                    update_req;
  logic                    busy;
  logic                    update_done;

  modport master (
    output glyph_in, digit_en_in, dp_in, blink_in, update_req,
    input  busy, update_done
  );

  modport slave (
    input  glyph_in, digit_en_in, dp_in, blink_in, update_req,
    output busy, update_done
  );
endinterface

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - multiplexed seven-segment scanner with blink, blanking gap
// and frame-aligned content commit
module seg_scan_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_scan_display_if.slave     bus,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [FW-1:0]           frame_cnt;
  logic                    blink_phase;
  logic                    busy_r;
  logic                    done_r;
  logic [4*NUM_DIGITS-1:0] act_glyph, pend_glyph;
  logic [NUM_DIGITS-1:0]   act_en, act_dp, act_blink;
  logic [NUM_DIGITS-1:0]   pend_en, pend_dp, pend_blink;

  logic                    slot_end;
  logic                    frame_end;
  logic                    dark;
  logic [3:0]              cur_glyph;
  logic [7:0]              table_seg;
  logic [7:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;

  assign bus.busy        = busy_r;
  assign bus.update_done = done_r;

  function automatic logic [7:0] decode(input logic [3:0] g);
    case (g)
      4'h0:    decode = 8'hC6;
      4'h1:    decode = 8'h83;
      4'h2:    decode = 8'h88;
      4'h3:    decode = 8'h90;
      4'h4:    decode = 8'h8E;
      4'h5:    decode = 8'h86;
      4'h6:    decode = 8'hA1;
      4'h7:    decode = 8'h46;
      4'h8:    decode = 8'hBF;
      default: decode = 8'hFF;
    endcase
  endfunction

  assign slot_end  = (cnt == CW'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx == IW'(NUM_DIGITS - 1));

  always_comb begin
    cur_glyph = act_glyph[4*int'(idx) +: 4];
    table_seg = decode(cur_glyph);
    // Blanking gap at slot start keeps the previous digit's segments from ghosting.
    dark      = (32'(cnt) < BLANK_CYCLES) || !act_en[idx] || (act_blink[idx] && blink_phase);
    seg_nxt   = 8'hFF;
    an_nxt    = '1;
    if (!dark) begin
      seg_nxt = {table_seg[7] & ~act_dp[idx], table_seg[6:0]};
      an_nxt  = ~(NUM_DIGITS'(1) << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      act_glyph   <= '1;
      pend_glyph  <= '1;
      act_en      <= '0;
      act_dp      <= '0;
      act_blink   <= '0;
      pend_en     <= '0;
      pend_dp     <= '0;
      pend_blink  <= '0;
      seg         <= 8'hFF;
      an          <= '1;
    end else begin
      seg    <= seg_nxt;
      an     <= an_nxt;
      done_r <= 1'b0;

      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end

      if (frame_end) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end

      // A commit takes priority; a request landing in the commit cycle is dropped.
      if (frame_end && busy_r) begin
        act_glyph <= pend_glyph;
        act_en    <= pend_en;
        act_dp    <= pend_dp;
        act_blink <= pend_blink;
        busy_r    <= 1'b0;
        done_r    <= 1'b1;
      end else if (bus.update_req && !busy_r) begin
        pend_glyph <= bus.glyph_in;
        pend_en    <= bus.digit_en_in;
        pend_dp    <= bus.dp_in;
        pend_blink <= bus.blink_in;
        busy_r     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - randomized bench for seg_scan_display with a cycle-count
// based reference model
module tb_seg_scan_display;
  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BL = 2;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] seg;
  logic [N-1:0] an;

  seg_scan_display_if #(.NUM_DIGITS(N)) bus ();

  seg_scan_display #(
    .NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BL), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] glyph_tbl [16];
  int         cyc;
  logic [15:0] m_act_g, m_pend_g;
  logic [3:0]  m_act_en, m_act_dp, m_act_blink, m_pend_en, m_pend_dp, m_pend_blink;
  logic        m_busy;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_done, exp_busy;
  int          done_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model state is a cycle count since reset; slot, digit, frame and blink phase derive from it.
  task automatic model_edge();
    int c, d, fe;
    bit ph;
    logic [3:0] g;
    exp_done = 1'b0;
    if (rst) begin
      cyc = 0;
      exp_seg = 8'hFF; exp_an = 4'hF;
      m_busy = 1'b0;
      m_act_g = 16'hFFFF; m_pend_g = 16'hFFFF;
      m_act_en = '0; m_act_dp = '0; m_act_blink = '0;
      m_pend_en = '0; m_pend_dp = '0; m_pend_blink = '0;
    end else begin
      c  = cyc % RD;
      d  = (cyc / RD) % N;
      fe = cyc / (RD * N);
      ph = ((fe / BF) % 2) == 1;
      g  = m_act_g[d*4 +: 4];
      if (c < BL || !m_act_en[d] || (m_act_blink[d] && ph)) begin
        exp_seg = 8'hFF; exp_an = 4'hF;
      end else begin
        exp_an  = ~(4'b0001 << d);
        exp_seg = glyph_tbl[g];
        if (m_act_dp[d]) exp_seg[7] = 1'b0;
      end
      if ((cyc % (RD * N)) == RD * N - 1 && m_busy) begin
        m_act_g = m_pend_g; m_act_en = m_pend_en;
        m_act_dp = m_pend_dp; m_act_blink = m_pend_blink;
        m_busy = 1'b0;
        exp_done = 1'b1;
      end else if (bus.update_req && !m_busy) begin
        m_pend_g = bus.glyph_in; m_pend_en = bus.digit_en_in;
        m_pend_dp = bus.dp_in; m_pend_blink = bus.blink_in;
        m_busy = 1'b1;
      end
      cyc++;
    end
    exp_busy = m_busy;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("seg", 32'(seg), 32'(exp_seg));
    check("an", 32'(an), 32'(exp_an));
    check("busy", 32'(bus.busy), 32'(exp_busy));
    check("done", 32'(bus.update_done), 32'(exp_done));
    if (bus.update_done === 1'b1) done_seen++;
    bus.update_req = 1'b0;
  endtask

  task automatic load(input logic [15:0] g, input logic [3:0] en, input logic [3:0] dp,
                      input logic [3:0] bl);
    bus.glyph_in = g; bus.digit_en_in = en; bus.dp_in = dp; bus.blink_in = bl;
    bus.update_req = 1'b1;
  endtask

  initial begin
    int guard;
    glyph_tbl = '{8'hC6, 8'h83, 8'h88, 8'h90, 8'h8E, 8'h86, 8'hA1, 8'h46,
                  8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    cyc = 0; m_busy = 1'b0; done_seen = 0;
    bus.glyph_in = '0; bus.digit_en_in = '0; bus.dp_in = '0; bus.blink_in = '0;
    bus.update_req = 1'b0;

    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    repeat (64) step();
    check("t1_busy", 32'(bus.busy), 0);
    check("t1_seg", 32'(seg), 32'h0FF);

    load(16'h3210, 4'hF, 4'h0, 4'h0);
    step();
    check("t2_busy", 32'(bus.busy), 1);
    done_seen = 0;
    repeat (64) step();
    check("t2_done_cnt", done_seen, 1);

    load(16'h8F97, 4'b1011, 4'b0001, 4'h0);
    step();
    repeat (64) step();

    load(16'h8F97, 4'hF, 4'b0001, 4'b0001);
    step();
    repeat (192) step();

    load(16'h0123, 4'hF, 4'h0, 4'h0);
    step(); step(); step();
    load(16'h4444, 4'hF, 4'hF, 4'h0);
    step();
    done_seen = 0;
    repeat (64) step();
    check("t5_single_done", done_seen, 1);

    guard = 0;
    while ((cyc % (RD * N)) != RD * N - 1 && guard < 100) begin
      step();
      guard++;
    end
    check("t5_align_timeout", 32'(guard < 100), 1);
    load(16'h5678, 4'hF, 4'h0, 4'h0);
    step();
    check("t5_fe_req_busy", 32'(bus.busy), 1);
    check("t5_fe_req_nodone", 32'(bus.update_done), 0);
    done_seen = 0;
    repeat (31) step();
    check("t5_no_early_commit", done_seen, 0);
    step();
    check("t5_late_commit", 32'(bus.update_done), 1);

    load(16'h2222, 4'hF, 4'h0, 4'h0);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_seg", 32'(seg), 32'h0FF);
    check("t6_an", 32'(an), 32'hF);
    check("t6_busy", 32'(bus.busy), 0);
    done_seen = 0;
    repeat (64) step();
    check("t6_no_done", done_seen, 0);

    repeat (3000) begin
      bus.glyph_in    = 16'($urandom);
      bus.digit_en_in = 4'($urandom);
      bus.dp_in       = 4'($urandom);
      bus.blink_in    = 4'($urandom);
      bus.update_req  = ($urandom_range(0, 7) == 0);
      rst             = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
